// File: rtl/axil_arb2.sv
// Two-master AXI-Lite arbiter: independent round-robin write and read arbiters
// sharing one downstream AXI-Lite port, one outstanding transaction per path.
module axil_arb2 #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,

  // master 0
  input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
  input  logic                      s0_awvalid,
  output logic                      s0_awready,
  input  logic [DATA_WIDTH-1:0]     s0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
  input  logic                      s0_wvalid,
  output logic                      s0_wready,
  output logic [1:0]                s0_bresp,
  output logic                      s0_bvalid,
  input  logic                      s0_bready,
  input  logic [ADDR_WIDTH-1:0]     s0_araddr,
  input  logic                      s0_arvalid,
  output logic                      s0_arready,
  output logic [DATA_WIDTH-1:0]     s0_rdata,
  output logic [1:0]                s0_rresp,
  output logic                      s0_rvalid,
  input  logic                      s0_rready,

  // master 1
  input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
  input  logic                      s1_awvalid,
  output logic                      s1_awready,
  input  logic [DATA_WIDTH-1:0]     s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
  input  logic                      s1_wvalid,
  output logic                      s1_wready,
  output logic [1:0]                s1_bresp,
  output logic                      s1_bvalid,
  input  logic                      s1_bready,
  input  logic [ADDR_WIDTH-1:0]     s1_araddr,
  input  logic                      s1_arvalid,
  output logic                      s1_arready,
  output logic [DATA_WIDTH-1:0]     s1_rdata,
  output logic [1:0]                s1_rresp,
  output logic                      s1_rvalid,
  input  logic                      s1_rready,

  // downstream slave
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_t;

  // Round-robin pick: lone requester wins, contention goes to the master not served last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req[0] && req[1]) return ~last;
    return req[1];
  endfunction

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t   w_state, w_state_nxt;
  logic       wgnt, wgnt_nxt;
  logic       wlast, wlast_nxt;
  logic       aw_done, aw_done_nxt;
  logic       w_done, w_done_nxt;
  logic [1:0] wreq;
  logic       sel_awvalid, sel_wvalid, sel_bready;
  logic       aw_hs, w_hs, b_hs;

  assign wreq        = {s1_awvalid | s1_wvalid, s0_awvalid | s0_wvalid};
  assign sel_awvalid = wgnt ? s1_awvalid : s0_awvalid;
  assign sel_wvalid  = wgnt ? s1_wvalid  : s0_wvalid;
  assign sel_bready  = wgnt ? s1_bready  : s0_bready;
  assign aw_hs       = m_awvalid & m_awready;
  assign w_hs        = m_wvalid & m_wready;
  assign b_hs        = m_bvalid & m_bready;

  // Payload muxes follow the registered grant; master 0 out of reset.
  assign m_awaddr = wgnt ? s1_awaddr : s0_awaddr;
  assign m_wdata  = wgnt ? s1_wdata  : s0_wdata;
  assign m_wstrb  = wgnt ? s1_wstrb  : s0_wstrb;
  assign s0_bresp = m_bresp;
  assign s1_bresp = m_bresp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      wgnt    <= 1'b0;
      wlast   <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      wgnt    <= wgnt_nxt;
      wlast   <= wlast_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    wgnt_nxt    = wgnt;
    wlast_nxt   = wlast;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    case (w_state)
      W_IDLE: begin
        if (wreq != 2'b00) begin
          wgnt_nxt    = rr_pick(wreq, wlast);
          w_state_nxt = W_DATA;
        end
      end
      W_DATA: begin
        // AW and W may complete in either order or together.
        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          w_state_nxt = W_RESP;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done | w_hs;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          wlast_nxt   = wgnt;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    s0_awready = 1'b0;
    s1_awready = 1'b0;
    s0_wready  = 1'b0;
    s1_wready  = 1'b0;
    s0_bvalid  = 1'b0;
    s1_bvalid  = 1'b0;
    case (w_state)
      W_DATA: begin
        m_awvalid = sel_awvalid & ~aw_done;
        m_wvalid  = sel_wvalid & ~w_done;
        if (wgnt) begin
          s1_awready = m_awready & ~aw_done;
          s1_wready  = m_wready & ~w_done;
        end else begin
          s0_awready = m_awready & ~aw_done;
          s0_wready  = m_wready & ~w_done;
        end
      end
      W_RESP: begin
        m_bready = sel_bready;
        if (wgnt) s1_bvalid = m_bvalid;
        else      s0_bvalid = m_bvalid;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t   r_state, r_state_nxt;
  logic       rgnt, rgnt_nxt;
  logic       rlast, rlast_nxt;
  logic [1:0] rreq;
  logic       sel_arvalid, sel_rready;
  logic       ar_hs, r_hs;

  assign rreq        = {s1_arvalid, s0_arvalid};
  assign sel_arvalid = rgnt ? s1_arvalid : s0_arvalid;
  assign sel_rready  = rgnt ? s1_rready  : s0_rready;
  assign ar_hs       = m_arvalid & m_arready;
  assign r_hs        = m_rvalid & m_rready;

  assign m_araddr = rgnt ? s1_araddr : s0_araddr;
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s1_rresp = m_rresp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rgnt    <= 1'b0;
      rlast   <= 1'b1;
    end else begin
      r_state <= r_state_nxt;
      rgnt    <= rgnt_nxt;
      rlast   <= rlast_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    rgnt_nxt    = rgnt;
    rlast_nxt   = rlast;
    case (r_state)
      R_IDLE: begin
        if (rreq != 2'b00) begin
          rgnt_nxt    = rr_pick(rreq, rlast);
          r_state_nxt = R_ADDR;
        end
      end
      R_ADDR: begin
        if (ar_hs) r_state_nxt = R_RESP;
      end
      R_RESP: begin
        if (r_hs) begin
          rlast_nxt   = rgnt;
          r_state_nxt = R_IDLE;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    case (r_state)
      R_ADDR: begin
        m_arvalid = sel_arvalid;
        if (rgnt) s1_arready = m_arready;
        else      s0_arready = m_arready;
      end
      R_RESP: begin
        m_rready = sel_rready;
        if (rgnt) s1_rvalid = m_rvalid;
        else      s0_rvalid = m_rvalid;
      end
      default: ;
    endcase
  end

endmodule
